dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dmem_pkg;

  localparam int unsigned XlenDefault  = 64;
  localparam int unsigned DepthDefault = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, combinational read, asynchronous clear.
module dmem_array #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed, parameterised response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN    = XlenDefault,
  parameter int unsigned DEPTH   = DepthDefault,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned    AW    = $clog2(DEPTH);
  localparam logic [XLEN-1:0] Limit = XLEN'(DEPTH * 8);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept;
  logic            addr_err;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] mem_rdata;

  assign req_ready = (state_q == StIdle) & ~reset;
  assign accept    = req_valid & req_ready;
  assign addr_err  = (req_addr[2:0] != 3'b000) | (req_addr >= Limit);
  assign idx       = req_addr[AW+2:3];

  // Faulting stores must never reach the array.
  dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (accept & req_we & ~addr_err),
    .addr  (idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rdata_q <= (req_we | addr_err) ? '0 : mem_rdata;
            err_q   <= addr_err;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, random traffic against a word-array model, corners.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        q1_req_valid, q1_req_ready, q1_req_we;
  logic [63:0] q1_req_addr, q1_req_wdata;
  logic        q1_rsp_valid, q1_rsp_ready, q1_rsp_err;
  logic [63:0] q1_rsp_rdata;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.XLEN(64), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (q1_req_valid),
    .req_ready (q1_req_ready),
    .req_we    (q1_req_we),
    .req_addr  (q1_req_addr),
    .req_wdata (q1_req_wdata),
    .rsp_valid (q1_rsp_valid),
    .rsp_ready (q1_rsp_ready),
    .rsp_rdata (q1_rsp_rdata),
    .rsp_err   (q1_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [63:0] a);
    return (a % 8 != 0) || (a >= 64'(DEPTH * 8));
  endfunction

  // Model: byte address -> word slot; stores land only when the address is legal.
  task automatic model_apply(input logic we, input logic [63:0] a, input logic [63:0] d);
    if (we && !addr_bad(a)) mem_m[int'(a / 8)] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input int hold, input logic exp_err, input logic [63:0] exp_data);
    int lat;
    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    // Scramble inputs: only the accept-edge values may matter.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    chk("ready_busy", 64'(req_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      rsp_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    chk("latency", 64'(lat), 64'(LAT));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", rsp_rdata, exp_data);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h0;
      req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, exp_data);
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_valid", 64'(rsp_valid), 64'd0);
    chk("release_ready", 64'(req_ready), 64'd1);
  endtask

  vec_t        tbl [10];
  logic        l1_we   [4];
  logic [63:0] l1_addr [4];
  logic [63:0] l1_data [4];
  logic [63:0] l1_exp  [4];

  initial begin
    logic        we, e;
    logic [63:0] a, d, x;
    int          sel;

    tbl[0] = '{1'b1, 64'h50, 64'h63,   0, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 64'h50, 64'h0,    0, 1'b0, 64'h63};
    tbl[2] = '{1'b0, 64'h53, 64'h0,    0, 1'b1, 64'h0};
    tbl[3] = '{1'b0, 64'h100, 64'h0,   1, 1'b1, 64'h0};
    tbl[4] = '{1'b1, 64'h53, 64'hFF,   0, 1'b1, 64'h0};
    tbl[5] = '{1'b0, 64'h50, 64'h0,    0, 1'b0, 64'h63};
    tbl[6] = '{1'b0, 64'hF8, 64'h0,    0, 1'b0, 64'h0};
    tbl[7] = '{1'b1, 64'hF8, 64'hDEAD, 0, 1'b0, 64'h0};
    tbl[8] = '{1'b0, 64'hF8, 64'h0,    5, 1'b0, 64'hDEAD};
    tbl[9] = '{1'b0, 64'h00, 64'h0,    0, 1'b0, 64'h0};

    l1_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    l1_addr = '{64'h10, 64'h10, 64'h18, 64'h18};
    l1_data = '{64'hA5, 64'h0, 64'h5A5A, 64'h0};
    l1_exp  = '{64'h0, 64'hA5, 64'h0, 64'h5A5A};

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    q1_req_valid = 1'b0; q1_req_we = 1'b0; q1_req_addr = '0; q1_req_wdata = '0;
    q1_rsp_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    chk("reset_valid_l1", 64'(q1_rsp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(req_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, tbl[i].err, tbl[i].rdata);
    end

    // Random traffic against the word-array model
    for (int n = 0; n < 40; n++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      a   = 64'($urandom_range(0, DEPTH - 1)) * 8;
      if (sel == 0) a = a + 64'($urandom_range(1, 7));
      else if (sel == 1) a = 64'($urandom_range(DEPTH, 4000)) * 8;
      d = {$urandom, $urandom};
      e = addr_bad(a);
      x = (we || e) ? 64'h0 : mem_m[int'(a / 8)];
      model_apply(we, a, d);
      txn(we, a, d, $urandom_range(0, 3), e, x);
    end

    // Reset while waiting on a store: response dropped, word cleared
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h08; req_wdata = 64'h37;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("wait_reset_valid", 64'(rsp_valid), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_reset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    txn(1'b0, 64'h08, 64'h0, 0, 1'b0, 64'h0);

    // Reset while a load response is pending
    model_apply(1'b1, 64'h50, 64'h11);
    txn(1'b1, 64'h50, 64'h11, 0, 1'b0, 64'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h50;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_pre_reset_valid", 64'(rsp_valid), 64'd1);
    chk("resp_pre_reset_rdata", rsp_rdata, 64'h11);
    reset = 1'b1;
    #1;
    chk("resp_reset_valid", 64'(rsp_valid), 64'd0);
    chk("resp_reset_rdata", rsp_rdata, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("resp_reset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    txn(1'b0, 64'h50, 64'h0, 0, 1'b0, 64'h0);

    // LATENCY=1 build: back-to-back with rsp_ready held high
    @(negedge clk);
    q1_rsp_ready = 1'b1;
    q1_req_valid = 1'b1;
    q1_req_we = l1_we[0]; q1_req_addr = l1_addr[0]; q1_req_wdata = l1_data[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("l1_valid", 64'(q1_rsp_valid), 64'd1);
        chk("l1_busy", 64'(q1_req_ready), 64'd0);
        chk("l1_rdata", q1_rsp_rdata, l1_exp[c / 2]);
        chk("l1_err", 64'(q1_rsp_err), 64'd0);
      end else begin
        chk("l1_valid_lo", 64'(q1_rsp_valid), 64'd0);
        chk("l1_ready", 64'(q1_req_ready), 64'd1);
        if ((c + 1) / 2 < 4) begin
          q1_req_we    = l1_we[(c + 1) / 2];
          q1_req_addr  = l1_addr[(c + 1) / 2];
          q1_req_wdata = l1_data[(c + 1) / 2];
        end else begin
          q1_req_valid = 1'b0;
        end
      end
    end
    q1_rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
